// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC trig front end and iteration core.
package cordic_pkg;

    localparam int unsigned FP_EXP_BIAS  = 127;
    localparam int unsigned FP_MANT_BITS = 23;
    localparam int unsigned CORDIC_WIDTH = 32;
    localparam int unsigned CORDIC_FRAC  = 30;

    localparam logic [CORDIC_WIDTH-1:0] FIX_MAX = {1'b0, {(CORDIC_WIDTH-1){1'b1}}};
    localparam logic [CORDIC_WIDTH-1:0] FIX_MIN = {1'b1, {(CORDIC_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/f2x_shifter.sv
// Combinational bidirectional barrel shifter: 24-bit significand to WIDTH-bit
// magnitude; right shifts also report the first dropped bit (guard) and sticky.
module f2x_shifter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [23:0]       m,
    input  logic signed [9:0] sh,
    output logic [WIDTH-1:0]  mag,
    output logic              guard,
    output logic              sticky
);

    logic [9:0]  r_amt;
    logic [48:0] r_wide;

    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        r_amt  = '0;
        r_wide = '0;
        if (!sh[9]) begin
            mag = WIDTH'(m) << sh[8:0];
        end else begin
            // 25 spare bits below the significand capture guard and sticky
            r_amt  = 10'(-sh);
            r_wide = {m, 25'b0} >> r_amt;
            mag    = WIDTH'(r_wide[48:25]);
            guard  = r_wide[24];
            sticky = |r_wide[23:0];
        end
    end

endmodule

// File: rtl/float_to_fixed.sv
// IEEE-754 single to signed Q(WIDTH-FRAC_BITS).FRAC_BITS, 3-stage pipeline with
// ovf/inv/unf flags. Define F2X_ROUND_NEAREST_EN for round-half-away rounding.
module float_to_fixed
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH     = CORDIC_WIDTH,
    parameter int unsigned FRAC_BITS = CORDIC_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [31:0]      in_float,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_fixed,
    output logic             out_ovf,
    output logic             out_inv,
    output logic             out_unf
);

    localparam int unsigned SHIFT_BIAS = FP_EXP_BIAS + FP_MANT_BITS - FRAC_BITS;
    localparam int unsigned OVF_EXP    = FP_EXP_BIAS + WIDTH - 1 - FRAC_BITS;
    localparam logic [WIDTH-1:0] SAT_POS = (WIDTH == CORDIC_WIDTH) ? WIDTH'(FIX_MAX)
                                                                   : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = (WIDTH == CORDIC_WIDTH) ? WIDTH'(FIX_MIN)
                                                                   : {1'b1, {(WIDTH-1){1'b0}}};

    fp32_t fp;

    logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic [7:0]       s1_exp_q, s1_exp_d;
    logic [23:0]      s1_mant_q, s1_mant_d;
    logic             s1_zero_q, s1_zero_d, s1_denorm_q, s1_denorm_d;
    logic             s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;

    logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic [WIDTH-1:0] s2_mag_q, s2_mag_d;
    logic             s2_ovf_q, s2_ovf_d, s2_inv_q, s2_inv_d;
    logic             s2_nan_q, s2_nan_d, s2_unf_q, s2_unf_d;

    logic             s3_valid_q, s3_valid_d;
    logic [WIDTH-1:0] s3_fixed_q, s3_fixed_d;
    logic             s3_ovf_q, s3_ovf_d, s3_inv_q, s3_inv_d, s3_unf_q, s3_unf_d;

    logic signed [9:0] sh;
    logic [WIDTH-1:0]  sh_mag, mag_fin;
    logic              guard, sticky, rnd_ovf;

    assign fp = in_float;
    assign sh = $signed({2'b00, s1_exp_q}) - $signed(10'(SHIFT_BIAS));

    f2x_shifter #(.WIDTH(WIDTH)) u_shifter (
        .m      (s1_mant_q),
        .sh     (sh),
        .mag    (sh_mag),
        .guard  (guard),
        .sticky (sticky)
    );

`ifdef F2X_ROUND_NEAREST_EN
    logic [WIDTH:0] rnd_sum;
    logic           unused_sticky;
    assign unused_sticky = sticky;
    assign rnd_sum = {1'b0, sh_mag} + (WIDTH+1)'(guard);
    assign mag_fin = rnd_sum[WIDTH-1:0];
    assign rnd_ovf = rnd_sum[WIDTH] | rnd_sum[WIDTH-1];
`else
    logic unused_gs;
    assign unused_gs = guard ^ sticky;
    assign mag_fin = sh_mag;
    assign rnd_ovf = 1'b0;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;  s1_sign_d = s1_sign_q;  s1_exp_d = s1_exp_q;
        s1_mant_d  = s1_mant_q;   s1_zero_d = s1_zero_q;  s1_denorm_d = s1_denorm_q;
        s1_nan_d   = s1_nan_q;    s1_inf_d  = s1_inf_q;
        s2_valid_d = s2_valid_q;  s2_sign_d = s2_sign_q;  s2_mag_d = s2_mag_q;
        s2_ovf_d   = s2_ovf_q;    s2_inv_d  = s2_inv_q;   s2_nan_d = s2_nan_q;
        s2_unf_d   = s2_unf_q;
        s3_valid_d = s3_valid_q;  s3_fixed_d = s3_fixed_q;
        s3_ovf_d   = s3_ovf_q;    s3_inv_d   = s3_inv_q;  s3_unf_d = s3_unf_q;
        if (clk_en) begin
            s1_valid_d  = in_valid;
            s1_sign_d   = fp.sign;
            s1_exp_d    = fp.exp;
            s1_mant_d   = {|fp.exp, fp.frac};
            s1_zero_d   = (fp.exp == '0) && (fp.frac == '0);
            s1_denorm_d = (fp.exp == '0) && (fp.frac != '0);
            s1_nan_d    = (fp.exp == '1) && (fp.frac != '0);
            s1_inf_d    = (fp.exp == '1) && (fp.frac == '0);

            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_mag_d   = mag_fin;
            s2_nan_d   = s1_nan_q;
            s2_inv_d   = s1_nan_q | s1_inf_q;
            s2_ovf_d   = !s2_inv_d && ((s1_exp_q >= 8'(OVF_EXP)) || rnd_ovf);
            s2_unf_d   = !s2_inv_d && !s2_ovf_d && !s1_zero_q
                         && (s1_denorm_q || (mag_fin == '0));

            s3_valid_d = s2_valid_q;
            s3_inv_d   = s2_inv_q;
            s3_ovf_d   = s2_ovf_q;
            s3_unf_d   = s2_unf_q;
            // NaN has no meaningful sign, so it always saturates positive
            if (s2_nan_q)
                s3_fixed_d = SAT_POS;
            else if (s2_inv_q || s2_ovf_q)
                s3_fixed_d = s2_sign_q ? SAT_NEG : SAT_POS;
            else if (s2_unf_q)
                s3_fixed_d = '0;
            else
                s3_fixed_d = s2_sign_q ? -s2_mag_q : s2_mag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_exp_q <= '0; s1_mant_q <= '0;
            s1_zero_q <= 1'b0; s1_denorm_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
            s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_mag_q <= '0; s2_ovf_q <= 1'b0;
            s2_inv_q <= 1'b0; s2_nan_q <= 1'b0; s2_unf_q <= 1'b0;
            s3_valid_q <= 1'b0; s3_fixed_q <= '0; s3_ovf_q <= 1'b0;
            s3_inv_q <= 1'b0; s3_unf_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_exp_q <= s1_exp_d;
            s1_mant_q <= s1_mant_d; s1_zero_q <= s1_zero_d; s1_denorm_q <= s1_denorm_d;
            s1_nan_q <= s1_nan_d; s1_inf_q <= s1_inf_d;
            s2_valid_q <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_mag_q <= s2_mag_d;
            s2_ovf_q <= s2_ovf_d; s2_inv_q <= s2_inv_d; s2_nan_q <= s2_nan_d;
            s2_unf_q <= s2_unf_d;
            s3_valid_q <= s3_valid_d; s3_fixed_q <= s3_fixed_d; s3_ovf_q <= s3_ovf_d;
            s3_inv_q <= s3_inv_d; s3_unf_q <= s3_unf_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_fixed = s3_fixed_q;
    assign out_ovf   = s3_ovf_q;
    assign out_inv   = s3_inv_q;
    assign out_unf   = s3_unf_q;

endmodule
